rca_seq_ctrl: RTL and testbench

Sequential wide-add controller that time-shares one 40-bit ripple-carry slice (`rca_40b`) to add operands of `WORDS`×40 bits, one slice per clock. Carry is held in a register between slices. It replaces a wide combinational ripple chain where area matters more than latency. Operands enter and results leave on valid/ready handshakes, so the block sits between an operand producer and a result consumer.

---
 rtl/rca_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_rca_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: wide adder that pushes WORDS x 40-bit slices through one
// shared 40-bit ripple-carry slice, one slice per clock. The carry between
// slices is held in a register. Operands come in and results go out on
// valid/ready handshakes.

// 40-bit ripple-carry slice, purely combinational.
module rca_40b (
  input  logic [39:0] a_i,
  input  logic [39:0] b_i,
  input  logic        c_i,
  output logic [39:0] s_o,
  output logic        c_o
);
  logic [40:0] c;

  assign c[0] = c_i;
  for (genvar i = 0; i < 40; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = c[40];
endmodule

module rca_seq_ctrl #(
  parameter  int WORDS = 2,
  localparam int W     = 40 * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [WORDS-1:0][39:0] a_q, b_q, sum_q;
  logic                   carry_q, cout_q;
  logic [IDXW-1:0]        idx_q;
  logic [39:0]            sl_sum;
  logic                   sl_c;
  logic                   last;

  assign last = (idx_q == IDXW'(WORDS - 1));

  // The single shared slice sees only registered operands and carry, so the
  // critical path is one 40-bit ripple regardless of WORDS.
  rca_40b u_slice (
    .a_i (a_q[idx_q]),
    .b_i (b_q[idx_q]),
    .c_i (carry_q),
    .s_o (sl_sum),
    .c_o (sl_c)
  );

  assign sum  = sum_q;
  assign cout = cout_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs, decoded from state only.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, then one slice per RUN cycle. idx stops on
  // the last slice instead of incrementing so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        idx_q   <= '0;
      end
      if (state_q == S_RUN) begin
        sum_q[idx_q] <= sl_sum;
        carry_q      <= sl_c;
        if (last) cout_q <= sl_c;
        else      idx_q  <= idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed and random-soak bench for rca_seq_ctrl, with one instance each
// for WORDS = 1..4 sharing clock and reset.
module tb_rca_seq_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid_v  [N];
  logic         out_ready_v [N];
  logic         cin_v       [N];
  logic [159:0] a_v         [N];
  logic [159:0] b_v         [N];
  logic         in_ready_v  [N];
  logic         out_valid_v [N];
  logic         cout_v      [N];
  logic         busy_v      [N];
  logic [159:0] sum_v       [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = 40 * (g + 1);
    logic [W-1:0] s;
    rca_seq_ctrl #(.WORDS(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .a         (a_v[g][W-1:0]),
      .b         (b_v[g][W-1:0]),
      .cin       (cin_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .sum       (s),
      .cout      (cout_v[g]),
      .busy      (busy_v[g])
    );
    assign sum_v[g] = 160'(s);
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [160:0] got, input logic [160:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] mask(input int k, input logic [159:0] v);
    logic [159:0] m;
    m = (160'd1 << (40 * (k + 1))) - 160'd1;
    return v & m;
  endfunction

  // Present operands for one cycle; returns at the negedge after the accept edge.
  task automatic start_op(input int k, input logic [159:0] a, input logic [159:0] b,
                          input logic c, input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready_v[k], 1'b1);
    a_v[k] = a; b_v[k] = b; cin_v[k] = c; in_valid_v[k] = 1'b1;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
  endtask

  // Count edges from accept until out_valid, bounded.
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take(input int k, input string tag);
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    chk({tag, "_ov_after_take"}, out_valid_v[k], 1'b0);
    chk({tag, "_ir_after_take"}, in_ready_v[k], 1'b1);
  endtask

  task automatic do_op(input int k, input logic [159:0] a, input logic [159:0] b, input logic c,
                       input logic [159:0] es, input logic ec, input string tag);
    int lat;
    start_op(k, a, b, c, tag);
    wait_done(k, lat);
    chk({tag, "_lat"}, 161'(lat), 161'(k + 1));
    chk({tag, "_sum"}, sum_v[k], es);
    chk({tag, "_cout"}, cout_v[k], ec);
    take(k, tag);
  endtask

  task automatic soak(input int k, input int ops);
    logic [160:0] exp_q[$];
    logic [160:0] e, got;
    logic [159:0] av, bv;
    logic         c;
    int acc = 0, nres = 0, cyc = 0;
    while (nres < ops && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready_v[k] = ($urandom_range(0, 9) < 6);
      if (out_valid_v[k] && out_ready_v[k]) begin
        got = 161'(sum_v[k]) | (161'(cout_v[k]) << (40 * (k + 1)));
        if (exp_q.size() == 0) chk("soak_extra", 161'd1, 161'd0);
        else begin
          e = exp_q.pop_front();
          chk("soak_res", got, e);
        end
        nres++;
      end
      if (acc < ops && $urandom_range(0, 9) < 7) begin
        av = mask(k, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        bv = mask(k, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        c  = 1'($urandom_range(0, 1));
        a_v[k] = av; b_v[k] = bv; cin_v[k] = c; in_valid_v[k] = 1'b1;
        if (in_ready_v[k]) begin
          exp_q.push_back(161'(av) + 161'(bv) + 161'(c));
          acc++;
        end
      end else begin
        in_valid_v[k] = 1'b0;
      end
    end
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    out_ready_v[k] = 1'b0;
    chk("soak_count", 161'(nres), 161'(ops));
    chk("soak_leftover", 161'(exp_q.size()), 161'd0);
  endtask

  logic [159:0] ones;
  int           lat;
  logic         seen;

  initial begin
    for (int k = 0; k < N; k++) begin
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0; cin_v[k] = 1'b0;
      a_v[k] = '0; b_v[k] = '0;
    end

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready_v[1], 1'b1);
    chk("rst_out_valid", out_valid_v[1], 1'b0);
    chk("rst_busy", busy_v[1], 1'b0);
    chk("rst_sum", sum_v[1], 160'd0);
    chk("rst_cout", cout_v[1], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready_v[1], 1'b1);
    chk("post_rst_out_valid", out_valid_v[1], 1'b0);
    chk("post_rst_busy", busy_v[1], 1'b0);

    // Carry across the 40-bit slice boundary.
    do_op(1, 160'h00FF_FFFF_FFFF, 160'd1, 1'b0, 160'h0100_0000_0000, 1'b0, "xslice");

    // Full wrap for WORDS = 1, 2, 4.
    for (int k = 0; k < N; k++) begin
      if (k == 2) continue;
      ones = mask(k, '1);
      do_op(k, ones, 160'd0, 1'b1, 160'd0, 1'b1, $sformatf("wrap_w%0d", k + 1));
    end

    // Backpressure in DONE with new operands waiting.
    start_op(1, 160'd3, 160'd4, 1'b0, "bp");
    wait_done(1, lat);
    chk("bp_lat", 161'(lat), 161'd2);
    a_v[1] = 160'd100; b_v[1] = 160'd200; cin_v[1] = 1'b0; in_valid_v[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sum", sum_v[1], 160'd7);
      chk("bp_cout", cout_v[1], 1'b0);
      chk("bp_in_ready", in_ready_v[1], 1'b0);
      chk("bp_out_valid", out_valid_v[1], 1'b1);
    end
    out_ready_v[1] = 1'b1;
    @(negedge clk);
    out_ready_v[1] = 1'b0;
    chk("bp_release_in_ready", in_ready_v[1], 1'b1);
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    chk("bp_accept_busy", busy_v[1], 1'b1);
    wait_done(1, lat);
    chk("bp2_lat", 161'(lat), 161'd2);
    chk("bp2_sum", sum_v[1], 160'd300);
    take(1, "bp2");

    // Asynchronous reset in RUN with idx = 2 (WORDS = 4).
    start_op(3, 160'd1234, 160'd1, 1'b0, "mid");
    repeat (2) @(negedge clk);
    chk("mid_busy_before", busy_v[3], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready_v[3], 1'b1);
    chk("mid_rst_out_valid", out_valid_v[3], 1'b0);
    chk("mid_rst_busy", busy_v[3], 1'b0);
    chk("mid_rst_sum", sum_v[3], 160'd0);
    chk("mid_rst_cout", cout_v[3], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_v[3]) seen = 1'b1;
    end
    chk("mid_no_out_valid", seen, 1'b0);
    do_op(3, 160'd5, 160'd7, 1'b0, 160'd12, 1'b0, "mid_next");

    // Random soak: 2000 operations over WORDS = 1, 2, 3.
    soak(0, 667);
    soak(1, 667);
    soak(2, 666);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
